// File: rtl/crc32_2word_check.sv
// rtl/crc32_2word_check.sv - receive-side CRC-32 frame checker for the 128-bit two-word datapath
// Optional feature macro: CRC32_2WORD_CHECK_ERRCNT_EN (builds the saturating err_cnt)
module crc32_2word_check #(
  parameter int TARGET_CHIP = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 din_valid,
  input  logic                 din_last,
  input  logic [127:0]         din,
  input  logic [31:0]          din_crc,
  input  logic                 err_cnt_clr,
  output logic                 crc_done,
  output logic                 crc_err,
  output logic [31:0]          crc_calc,
  output logic [CNT_WIDTH-1:0] err_cnt
);

  // Reflected form of 0x04C11DB7; bits are consumed lsbit first.
  localparam logic [31:0] POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC_SEED  = 32'hFFFFFFFF;

  typedef enum logic [0:0] {IDLE, IN_FRAME} state_t;

  state_t         state;
  logic           s1_valid;
  logic           s1_last;
  logic           s1_first;
  logic [127:0]   s1_data;
  logic [31:0]    s1_crc;
  logic [31:0]    crc_run;
  logic           s2_done;
  logic [31:0]    s2_crc;
  logic [31:0]    crc_seed;
  logic [31:0]    crc_next;

  // Bit-serial reference folded into a pure XOR network; din[0] is the first bit on the wire.
  function automatic logic [31:0] crc_fold64(input logic [31:0] c, input logic [63:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 64; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ POLY_REFL;
      else             r = r >> 1;
    end
    return r;
  endfunction

  function automatic logic [31:0] crc_fold128(input logic [31:0] c, input logic [127:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 128; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ POLY_REFL;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // Frame tracking FSM plus stage-1 input registers; first-word flag drives the seed mux.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_first <= 1'b0;
      s1_data  <= '0;
      s1_crc   <= '0;
    end else begin
      s1_valid <= din_valid;
      s1_last  <= din_valid & din_last;
      if (din_valid) begin
        s1_data  <= din;
        s1_first <= (state == IDLE);
        state    <= din_last ? IDLE : IN_FRAME;
      end
      if (din_valid && din_last) begin
        s1_crc <= din_crc;
      end
    end
  end

  // A new frame reseeds straight from the flag, so back-to-back frames need no bubble.
  assign crc_seed = s1_first ? CRC_SEED : crc_run;

  generate
    if (TARGET_CHIP >= 2) begin : g_xor_lut6
      // 6-input LUT families: one flat 128-bit tree, left for the mapper to balance.
      assign crc_next = crc_fold128(crc_seed, s1_data);
    end else begin : g_xor_lut4
      // Narrower LUT families: split into the two 64-bit halves in wire order.
      assign crc_next = crc_fold64(crc_fold64(crc_seed, s1_data[63:0]), s1_data[127:64]);
    end
  endgenerate

  // Stage 2: running CRC register and the end-of-frame marker with its received CRC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_run <= '0;
      s2_done <= 1'b0;
      s2_crc  <= '0;
    end else begin
      s2_done <= s1_valid & s1_last;
      if (s1_valid) begin
        crc_run <= crc_next;
      end
      if (s1_valid && s1_last) begin
        s2_crc <= s1_crc;
      end
    end
  end

  // Stage 3: registered compare and result; crc_calc holds until the next frame result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_done <= 1'b0;
      crc_err  <= 1'b0;
      crc_calc <= '0;
    end else begin
      crc_done <= s2_done;
      if (s2_done) begin
        crc_calc <= crc_run;
        crc_err  <= (crc_run != s2_crc);
      end else begin
        crc_err  <= 1'b0;
      end
    end
  end

`ifdef CRC32_2WORD_CHECK_ERRCNT_EN
  // Saturating mismatch counter; a clear wins over a same-cycle error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (err_cnt_clr) begin
      err_cnt <= '0;
    end else if (crc_done && crc_err && !(&err_cnt)) begin
      err_cnt <= err_cnt + CNT_WIDTH'(1);
    end
  end
`else
  logic unused_err_cnt_clr;
  assign unused_err_cnt_clr = err_cnt_clr;
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_crc32_2word_check.sv
// tb/tb_crc32_2word_check.sv - directed self-checking bench for crc32_2word_check
module tb_crc32_2word_check;

  localparam int CW = 4;
`ifdef CRC32_2WORD_CHECK_ERRCNT_EN
  localparam bit ERRCNT_ON = 1'b1;
`else
  localparam bit ERRCNT_ON = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          din_valid;
  logic          din_last;
  logic [127:0]  din;
  logic [31:0]   din_crc;
  logic          err_cnt_clr;
  logic          crc_done;
  logic          crc_err;
  logic [31:0]   crc_calc;
  logic [CW-1:0] err_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;
  int cyc      = 0;

  bit          done_err[$];
  logic [31:0] done_calc[$];
  int          done_cyc[$];

  crc32_2word_check #(.TARGET_CHIP(2), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din_last(din_last),
    .din(din), .din_crc(din_crc), .err_cnt_clr(err_cnt_clr),
    .crc_done(crc_done), .crc_err(crc_err), .crc_calc(crc_calc), .err_cnt(err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (crc_done === 1'b1) begin
      done_err.push_back(crc_err);
      done_calc.push_back(crc_calc);
      done_cyc.push_back(cyc);
    end
  end

  // Byte-wise reflected CRC-32 model: bytes 0..15 in order, each lsbit first.
  function automatic logic [31:0] crc_model(input logic [31:0] seed, input logic [127:0] w);
    logic [31:0] c;
    logic [7:0]  b;
    c = seed;
    for (int k = 0; k < 16; k++) begin
      b = w[8*k +: 8];
      c[7:0] = c[7:0] ^ b;
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  function automatic void bump_cnt();
    if (ERRCNT_ON && exp_cnt < 15) exp_cnt++;
  endfunction

  task automatic drive(input logic v, input logic l, input logic [127:0] d, input logic [31:0] c);
    @(negedge clk);
    din_valid = v;
    din_last  = l;
    din       = d;
    din_crc   = c;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0);
  endtask

  task automatic clear_q();
    done_err.delete();
    done_calc.delete();
    done_cyc.delete();
  endtask

  task automatic wait_done(input int n, input string name);
    int waited;
    waited = 0;
    while (done_err.size() < n && waited < 60) begin
      drive(1'b0, 1'b0, '0, '0);
      #1;
      waited++;
    end
    n_checks++;
    if (done_err.size() != n) begin
      n_fail++;
      $display("FAIL %s: crc_done pulses got %0d, need %0d", name, done_err.size(), n);
    end
  endtask

  task automatic check_result(input int idx, input bit e_err, input logic [31:0] e_calc, input string name);
    n_checks++;
    if (done_err.size() <= idx || done_err[idx] !== e_err) begin
      n_fail++;
      $display("FAIL %s crc_err: got %0b, need %0b", name, (done_err.size() > idx) ? done_err[idx] : 1'bx, e_err);
    end
    n_checks++;
    if (done_calc.size() <= idx || done_calc[idx] !== e_calc) begin
      n_fail++;
      $display("FAIL %s crc_calc: got %08h, need %08h", name, (done_calc.size() > idx) ? done_calc[idx] : 32'hx, e_calc);
    end
  endtask

  task automatic check_cnt(input string name);
    n_checks++;
    if (err_cnt !== CW'(exp_cnt)) begin
      n_fail++;
      $display("FAIL %s err_cnt: got %0d, need %0d", name, err_cnt, exp_cnt);
    end
  endtask

  task automatic check_all_zero(input string name);
    n_checks++;
    if ({crc_done, crc_err, crc_calc, err_cnt} !== '0) begin
      n_fail++;
      $display("FAIL %s outputs: got done=%b err=%b calc=%08h cnt=%0d, need all 0",
               name, crc_done, crc_err, crc_calc, err_cnt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    din_valid = 1'b0; din_last = 1'b0; din = '0; din_crc = '0; err_cnt_clr = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_hold");
    rst_n = 1'b1;
    idle(2);
    check_all_zero("reset_release");
  endtask

  task automatic test_one_word();
    logic [31:0] e;
    e = crc_model(32'hFFFFFFFF, '0);
    clear_q();
    drive(1'b1, 1'b1, '0, e);
    for (int k = 1; k <= 4; k++) begin
      idle(1);
      n_checks++;
      if (crc_done !== (k == 3)) begin
        n_fail++;
        $display("FAIL one_word crc_done at edge %0d: got %b, need %b", k, crc_done, (k == 3));
      end
    end
    check_result(0, 1'b0, e, "one_word");
    check_cnt("one_word");
  endtask

  task automatic test_gaps();
    logic [127:0] w[4];
    int           gap[3];
    logic [31:0]  e;
    w[0] = 128'h0123456789abcdef_fedcba9876543210;
    w[1] = 128'hdeadbeefcafef00d_0000000000000001;
    w[2] = 128'hffffffffffffffff_8000000000000000;
    w[3] = 128'h5a5a5a5aa5a5a5a5_0f0f0f0ff0f0f0f0;
    gap[0] = 0; gap[1] = 1; gap[2] = 3;
    e = 32'hFFFFFFFF;
    for (int i = 0; i < 4; i++) e = crc_model(e, w[i]);
    for (int pass = 0; pass < 2; pass++) begin
      clear_q();
      for (int i = 0; i < 4; i++) begin
        drive(1'b1, (i == 3), w[i], (pass == 0) ? e : (e ^ 32'h1));
        if (i < 3) idle(gap[i]);
      end
      wait_done(1, "gaps");
      check_result(0, (pass == 1), e, (pass == 0) ? "gaps_good" : "gaps_bad");
      if (pass == 1) bump_cnt();
      idle(2);
      check_cnt((pass == 0) ? "gaps_good" : "gaps_bad");
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] w[6];
    logic [127:0] sent;
    logic [31:0]  good[3];
    logic [31:0]  bad_b;
    for (int i = 0; i < 6; i++) w[i] = {4{32'h9e3779b9 * (i + 1)}};
    for (int f = 0; f < 3; f++) good[f] = crc_model(crc_model(32'hFFFFFFFF, w[2*f]), w[2*f+1]);
    sent = w[3] ^ (128'h1 << 64);
    bad_b = crc_model(crc_model(32'hFFFFFFFF, w[2]), sent);
    clear_q();
    for (int i = 0; i < 6; i++) drive(1'b1, i[0], (i == 3) ? sent : w[i], good[i/2]);
    wait_done(3, "b2b");
    check_result(0, 1'b0, good[0], "b2b_frame0");
    check_result(1, 1'b1, bad_b,   "b2b_frame1");
    check_result(2, 1'b0, good[2], "b2b_frame2");
    n_checks++;
    if (done_cyc.size() != 3 || done_cyc[1] - done_cyc[0] != 2 || done_cyc[2] - done_cyc[1] != 2) begin
      n_fail++;
      $display("FAIL b2b spacing: got %0d pulses, need 3 pulses 2 cycles apart", done_cyc.size());
    end
    bump_cnt();
    idle(2);
    check_cnt("b2b");
  endtask

  task automatic test_saturate_clear();
    logic [127:0] d;
    logic [31:0]  e;
    int           gaps;
    clear_q();
    for (int i = 0; i < 17; i++) begin
      d = {96'h0, 32'(i * 32'h01010101 + 7)};
      drive(1'b1, 1'b1, d, ~crc_model(32'hFFFFFFFF, d));
      bump_cnt();
    end
    wait_done(17, "saturate");
    gaps = 0;
    for (int i = 0; i < done_err.size(); i++) begin
      if (done_err[i] !== 1'b1) gaps++;
      if (i > 0 && done_cyc[i] != done_cyc[i-1] + 1) gaps++;
    end
    n_checks++;
    if (gaps != 0) begin
      n_fail++;
      $display("FAIL saturate pulses: got %0d non-error or non-consecutive pulses, need 0", gaps);
    end
    idle(2);
    check_cnt("saturate");
    d = 128'h1234;
    e = crc_model(32'hFFFFFFFF, d);
    drive(1'b1, 1'b1, d, e ^ 32'h8000_0000);
    idle(2);
    drive(1'b0, 1'b0, '0, '0);
    err_cnt_clr = 1'b1;
    n_checks++;
    if (crc_done !== 1'b1 || crc_err !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_collide done/err: got %b/%b, need 1/1", crc_done, crc_err);
    end
    @(negedge clk);
    err_cnt_clr = 1'b0;
    exp_cnt = 0;
    check_cnt("clear_collide");
  endtask

  task automatic test_mid_reset();
    logic [127:0] w;
    logic [31:0]  e;
    clear_q();
    drive(1'b1, 1'b0, 128'hAAAA_5555_0000_1111_2222_3333_4444_5555, '0);
    drive(1'b1, 1'b0, 128'h6666_7777_8888_9999_aaaa_bbbb_cccc_dddd, '0);
    drive(1'b0, 1'b0, '0, '0);
    #2 rst_n = 1'b0;
    #1 check_all_zero("mid_reset");
    exp_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(8);
    n_checks++;
    if (done_err.size() != 0) begin
      n_fail++;
      $display("FAIL mid_reset discard: got %0d crc_done pulses, need 0", done_err.size());
    end
    w = 128'h0f1e2d3c4b5a6978_8796a5b4c3d2e1f0;
    e = crc_model(32'hFFFFFFFF, w);
    drive(1'b1, 1'b1, w, e);
    wait_done(1, "post_reset");
    check_result(0, 1'b0, e, "post_reset");
    check_cnt("post_reset");
  endtask

  initial begin
    test_reset();
    test_one_word();
    test_gaps();
    test_back_to_back();
    test_saturate_clear();
    test_mid_reset();
    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
